// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline control blocks:
//   - RV32 opcode constants used to classify instructions
//   - the destination tag carried down the shadow pipeline (rd/wen/is_load/valid)
//   - instruction field extractors (opcode, rd, rs1, rs2)
//   - the tag-versus-source match rule used by forwarding and load-use logic
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

   // Tag rd field is sized for the largest register file we expect to build;
   // narrower register indices are zero-extended into it.
   localparam int TAG_AW = 8;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [TAG_AW-1:0] rd;
      logic              wen;
      logic              is_load;
      logic              valid;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   localparam tag_t TAG_INVALID = '{rd: {TAG_AW{1'b0}}, wen: 1'b0, is_load: 1'b0, valid: 1'b0};

   function automatic logic [6:0] get_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [4:0] get_rd(input logic [31:0] instr);
      return instr[11:7];
   endfunction

   function automatic logic [4:0] get_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] get_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   // A producer tag supplies source src only if it is a live write to a
   // register other than x0 (x0 reads as zero and is never bypassed).
   function automatic logic tag_match(input tag_t tag, input logic [TAG_AW-1:0] src);
      return tag.valid & tag.wen & (tag.rd != {TAG_AW{1'b0}}) & (tag.rd == src);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Bypass selector for one EX-stage source operand. Compares the operand's
// register index against the MEM and WB destination tags and picks the
// youngest producer, falling back to the register-file value.
// Ports:
//   src          in   AW      register index read by the EX instruction
//   mem_tag      in   TAG_W   destination tag of the instruction in MEM
//   wb_tag       in   TAG_W   destination tag of the instruction in WB
//   rf_val       in   XLEN    register-file value for this source
//   ex_mem_val   in   XLEN    ALU result held in EX/MEM
//   mem_wb_alu   in   XLEN    ALU result held in MEM/WB
//   mem_wb_load  in   XLEN    load data held in MEM/WB
//   operand      out  XLEN    bypassed operand
// ---------------------------------------------------------------------------
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic [AW-1:0]    src,
   input  logic [TAG_W-1:0] mem_tag,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic [XLEN-1:0]  rf_val,
   input  logic [XLEN-1:0]  ex_mem_val,
   input  logic [XLEN-1:0]  mem_wb_alu,
   input  logic [XLEN-1:0]  mem_wb_load,
   output logic [XLEN-1:0]  operand
);

   tag_t              mem_t_s;
   tag_t              wb_t_s;
   logic [TAG_AW-1:0] src_ext_s;
   logic              unused_mem_load_s;

   assign mem_t_s   = tag_t'(mem_tag);
   assign wb_t_s    = tag_t'(wb_tag);
   assign src_ext_s = TAG_AW'(src);

   // A load sitting in MEM never feeds EX (load-use stall prevents it), so
   // its is_load flag plays no part in the selection here.
   assign unused_mem_load_s = mem_t_s.is_load;

   // Youngest producer wins: MEM is checked before WB.
   always_comb begin
      operand = rf_val;
      if (tag_match(mem_t_s, src_ext_s)) begin
         operand = ex_mem_val;
      end else if (tag_match(wb_t_s, src_ext_s)) begin
         if (wb_t_s.is_load) begin
            operand = mem_wb_load;
         end else begin
            operand = mem_wb_alu;
         end
      end else begin
         operand = rf_val;
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Forwarding and hazard control for the IF/ID/EX/MEM/WB pipeline. Keeps a
// shadow pipeline of destination tags for EX, MEM and WB, drives the EX
// operand bypass muxes, detects load-use hazards (stall + bubble), freezes
// the pipe while data memory is busy, honours branch flushes and counts
// stall cycles (saturating).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs             NSRC*AW   ID source indices (slice k = source k)
//   id_rs_used        NSRC      ID source k is actually read
//   id_rd             AW        ID destination
//   id_wen, id_is_load          ID writes rd / ID is a load
//   flush             kill IF/ID and ID/EX on redirect
//   dmem_ready        data memory finished the access in MEM
//   rf_val            NSRC*XLEN register-file values for EX instruction
//   ex_mem_val        ALU result in EX/MEM
//   mem_wb_alu        ALU result in MEM/WB
//   mem_wb_load       load data in MEM/WB
//   operand           NSRC*XLEN bypassed EX operands
//   stall_fd          hold PC and IF/ID
//   bubble_ex         inject NOP into ID/EX
//   freeze            hold every pipeline register
//   stall_cnt         CNT_W     cycles with stall_fd or freeze asserted
// ---------------------------------------------------------------------------
module hazard_fwd_unit
   import pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int NSRC  = 2,
   parameter int CNT_W = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [NSRC*AW-1:0]   id_rs,
   input  logic [NSRC-1:0]      id_rs_used,
   input  logic [AW-1:0]        id_rd,
   input  logic                 id_wen,
   input  logic                 id_is_load,
   input  logic                 flush,
   input  logic                 dmem_ready,
   input  logic [NSRC*XLEN-1:0] rf_val,
   input  logic [XLEN-1:0]      ex_mem_val,
   input  logic [XLEN-1:0]      mem_wb_alu,
   input  logic [XLEN-1:0]      mem_wb_load,
   output logic [NSRC*XLEN-1:0] operand,
   output logic                 stall_fd,
   output logic                 bubble_ex,
   output logic                 freeze,
   output logic [CNT_W-1:0]     stall_cnt
);

   tag_t               ex_tag_r;
   tag_t               mem_tag_r;
   tag_t               wb_tag_r;
   logic [NSRC*AW-1:0] ex_rs_r;
   logic [CNT_W-1:0]   stall_cnt_r;

   tag_t               id_tag_s;
   logic               rs_hit_s;
   logic               load_use_s;
   logic               freeze_s;
   logic               stall_fd_s;
   logic               bubble_ex_s;

   assign id_tag_s = '{rd: TAG_AW'(id_rd), wen: id_wen, is_load: id_is_load, valid: 1'b1};

   // Does any source the ID instruction really reads match the EX destination?
   always_comb begin
      rs_hit_s = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         rs_hit_s = rs_hit_s | (id_rs_used[k] & tag_match(ex_tag_r, TAG_AW'(id_rs[k*AW +: AW])));
      end
   end

   assign load_use_s = id_valid & ex_tag_r.is_load & rs_hit_s;

   // A load in MEM whose data is not back yet stalls the whole pipe.
   assign freeze_s = mem_tag_r.valid & mem_tag_r.is_load & ~dmem_ready;

   // Priority freeze > flush > load-use. Under freeze the bubble is withheld
   // because ID/EX holds; under flush the consumer is being killed anyway.
   assign stall_fd_s  = freeze_s | (~flush & load_use_s);
   assign bubble_ex_s = ~freeze_s & ~flush & load_use_s;

   assign stall_fd  = stall_fd_s;
   assign bubble_ex = bubble_ex_s;
   assign freeze    = freeze_s;
   assign stall_cnt = stall_cnt_r;

   // Shadow tag pipeline; every stage holds while frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_tag_r  <= TAG_INVALID;
         mem_tag_r <= TAG_INVALID;
         wb_tag_r  <= TAG_INVALID;
         ex_rs_r   <= {(NSRC*AW){1'b0}};
      end else if (!freeze_s) begin
         if (flush | bubble_ex_s | ~id_valid) begin
            ex_tag_r <= TAG_INVALID;
         end else begin
            ex_tag_r <= id_tag_s;
         end
         ex_rs_r   <= id_rs;
         mem_tag_r <= ex_tag_r;
         wb_tag_r  <= mem_tag_r;
      end
   end

   // Saturating count of cycles lost to stalls or freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if ((stall_fd_s | freeze_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
   end

   // One bypass selector per EX source operand.
   for (genvar k = 0; k < NSRC; k++) begin : g_src
      fwd_mux #(
         .XLEN (XLEN),
         .AW   (AW)
      ) u_fwd (
         .src         (ex_rs_r[k*AW +: AW]),
         .mem_tag     (mem_tag_r),
         .wb_tag      (wb_tag_r),
         .rf_val      (rf_val[k*XLEN +: XLEN]),
         .ex_mem_val  (ex_mem_val),
         .mem_wb_alu  (mem_wb_alu),
         .mem_wb_load (mem_wb_load),
         .operand     (operand[k*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
`timescale 1ns/1ps
module tb_hazard_fwd_unit;
   import pipe_pkg::*;

   localparam int XLEN    = 32;
   localparam int NREG    = 32;
   localparam int NSRC    = 2;
   localparam int CNT_W   = 4;
   localparam int AW      = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int OW      = NSRC * XLEN;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 id_valid = 1'b0;
   logic [NSRC*AW-1:0]   id_rs = '0;
   logic [NSRC-1:0]      id_rs_used = '0;
   logic [AW-1:0]        id_rd = '0;
   logic                 id_wen = 1'b0;
   logic                 id_is_load = 1'b0;
   logic                 flush = 1'b0;
   logic                 dmem_ready = 1'b1;
   logic [OW-1:0]        rf_val = '0;
   logic [XLEN-1:0]      ex_mem_val = '0;
   logic [XLEN-1:0]      mem_wb_alu = '0;
   logic [XLEN-1:0]      mem_wb_load = '0;
   logic [OW-1:0]        operand;
   logic                 stall_fd;
   logic                 bubble_ex;
   logic                 freeze;
   logic [CNT_W-1:0]     stall_cnt;

   hazard_fwd_unit #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .flush(flush),
      .dmem_ready(dmem_ready), .rf_val(rf_val), .ex_mem_val(ex_mem_val),
      .mem_wb_alu(mem_wb_alu), .mem_wb_load(mem_wb_load), .operand(operand),
      .stall_fd(stall_fd), .bubble_ex(bubble_ex), .freeze(freeze), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [OW-1:0]    operand;
      logic             stall_fd;
      logic             bubble_ex;
      logic             freeze;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the instructions in flight, stage 0=EX, 1=MEM, 2=WB.
   bit  m_valid[3];
   int  m_rd[3];
   bit  m_wen[3];
   bit  m_load[3];
   int  m_ex_rs[NSRC];
   bit  m_ex_used[NSRC];
   int  m_cnt;
   bit  m_stall;

   // Data-path stimulus for the current cycle.
   logic [XLEN-1:0] g_rf[NSRC];
   logic [XLEN-1:0] g_exm, g_wba, g_wbl;
   int              g_dready_hold = 0;
   bit              g_rand_dready = 1'b0;

   function automatic bit writes(input int s, input int r);
      return m_valid[s] && m_wen[s] && (m_rd[s] != 0) && (m_rd[s] == r);
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 3; s++) begin
         m_valid[s] = 1'b0; m_rd[s] = 0; m_wen[s] = 1'b0; m_load[s] = 1'b0;
      end
      for (int k = 0; k < NSRC; k++) begin
         m_ex_rs[k] = 0; m_ex_used[k] = 1'b0;
      end
      m_cnt = 0;
   endtask

   task automatic randomize_data();
      for (int k = 0; k < NSRC; k++) g_rf[k] = $urandom;
      g_exm = $urandom; g_wba = $urandom; g_wbl = $urandom;
   endtask

   // One clock of stimulus: drive inputs, push the expected response, advance the model.
   task automatic cycle(input bit r, input bit v, input int rs0, input int rs1,
                        input bit [1:0] used, input int rd, input bit wen, input bit ld, input bit fl);
      exp_t e;
      int   rsv[NSRC];
      bit   dr, fz, lu, st, bb;
      @(posedge clk); #1;
      rsv[0] = rs0; rsv[1] = rs1;
      if (r) model_clear();
      dr = 1'b1;
      if (g_rand_dready) dr = ($urandom_range(0, 3) != 0);
      else if (m_valid[1] && m_load[1] && g_dready_hold > 0) begin
         dr = 1'b0; g_dready_hold--;
      end
      rst = r; id_valid = v; id_rs_used = used; id_rd = rd[AW-1:0];
      id_wen = wen; id_is_load = ld; flush = fl; dmem_ready = dr;
      for (int k = 0; k < NSRC; k++) begin
         id_rs[k*AW +: AW]    = rsv[k][AW-1:0];
         rf_val[k*XLEN +: XLEN] = g_rf[k];
      end
      ex_mem_val = g_exm; mem_wb_alu = g_wba; mem_wb_load = g_wbl;

      fz = m_valid[1] && m_load[1] && !dr;
      lu = 1'b0;
      if (v && m_valid[0] && m_load[0])
         for (int k = 0; k < NSRC; k++) if (used[k] && writes(0, rsv[k])) lu = 1'b1;
      st = fz || (lu && !fl);
      bb = !fz && !fl && lu;
      for (int k = 0; k < NSRC; k++) begin
         logic [XLEN-1:0] val;
         val = g_rf[k];
         if (writes(1, m_ex_rs[k])) val = g_exm;
         else if (writes(2, m_ex_rs[k])) val = m_load[2] ? g_wbl : g_wba;
         e.operand[k*XLEN +: XLEN] = val;
      end
      e.stall_fd = st; e.bubble_ex = bb; e.freeze = fz; e.cnt = m_cnt[CNT_W-1:0];
      exp_q.push_back(e);
      m_stall = st;

      if (m_valid[0] && m_valid[1] && m_load[1])
         for (int k = 0; k < NSRC; k++)
            if (m_ex_used[k] && writes(1, m_ex_rs[k])) begin
               errors++;
               $display("FAIL mem_load_to_ex src%0d reg %0d got load in MEM required none at %0t", k, m_ex_rs[k], $time);
            end

      if (r) model_clear();
      else begin
         if ((st || fz) && m_cnt < CNT_MAX) m_cnt++;
         if (!fz) begin
            for (int s = 2; s > 0; s--) begin
               m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1];
               m_wen[s] = m_wen[s-1]; m_load[s] = m_load[s-1];
            end
            m_valid[0] = !(fl || bb || !v); m_rd[0] = rd; m_wen[0] = wen; m_load[0] = ld;
            if (!m_valid[0]) begin m_rd[0] = 0; m_wen[0] = 1'b0; m_load[0] = 1'b0; end
            for (int k = 0; k < NSRC; k++) begin
               m_ex_rs[k] = rsv[k]; m_ex_used[k] = used[k];
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // Issue an encoded instruction into ID, re-presenting it while ID is stalled.
   task automatic issue(input logic [31:0] ins, input bit fl = 1'b0);
      logic [6:0] op;
      bit         ld, wen;
      int         n;
      op  = get_opcode(ins);
      ld  = (op == OP_LOAD);
      wen = (op != OP_STORE) && (op != OP_BRANCH);
      n   = 0;
      do begin
         cycle(1'b0, 1'b1, int'(get_rs1(ins)), int'(get_rs2(ins)), ld ? 2'b01 : 2'b11,
               int'(get_rd(ins)), wen, ld, fl);
         n++;
      end while (m_stall && !fl && n < 64);
   endtask

   function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h000, rs1, 3'b010, rd, OP_LOAD};
   endfunction

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h at %0t", nm, act, req, $time);
      end
   endtask

   // Compare each cycle's DUT outputs with the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("operand",   operand,             e.operand);
         chk("stall_fd",  OW'(stall_fd),       OW'(e.stall_fd));
         chk("bubble_ex", OW'(bubble_ex),      OW'(e.bubble_ex));
         chk("freeze",    OW'(freeze),         OW'(e.freeze));
         chk("stall_cnt", OW'(stall_cnt),      OW'(e.cnt));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      int  rr0, rr1, rrd;
      bit  rvv, rw, rl, rfl;
      bit [1:0] ru;
      model_clear();
      m_stall = 1'b0;
      randomize_data();
      do_reset(3);

      // back-to-back ALU dependency via EX/MEM
      g_exm = 32'h11;
      issue(r_op(5'd5, 5'd1, 5'd2)); issue(r_op(5'd6, 5'd5, 5'd1)); idle(3);

      // dependency two apart via MEM/WB, then MEM beats WB for the same register
      randomize_data(); g_wba = 32'h22; g_exm = 32'h33;
      for (int k = 0; k < NSRC; k++) g_rf[k] = 32'h0;
      issue(r_op(5'd5, 5'd1, 5'd2)); issue(NOP); issue(r_op(5'd9, 5'd5, 5'd5)); idle(3);
      issue(r_op(5'd5, 5'd1, 5'd2)); issue(r_op(5'd5, 5'd3, 5'd4)); issue(r_op(5'd10, 5'd5, 5'd5)); idle(3);

      // load-use: one stall then load data forwarded from WB
      do_reset(1);
      randomize_data(); g_wbl = 32'hDEAD;
      issue(lw(5'd7, 5'd1)); issue(r_op(5'd8, 5'd7, 5'd7)); idle(3);

      // data memory not ready for three cycles while a load is in MEM
      g_dready_hold = 3;
      issue(lw(5'd3, 5'd1)); issue(NOP); issue(NOP); issue(NOP); idle(4);

      // flush coinciding with load-use; x0 producer never forwards
      issue(lw(5'd7, 5'd1)); issue(r_op(5'd8, 5'd7, 5'd1), 1'b1); idle(3);
      randomize_data();
      issue(r_op(5'd0, 5'd1, 5'd2)); issue(r_op(5'd9, 5'd0, 5'd0)); idle(3);

      // long freeze saturates the counter, then reset lands mid-freeze
      g_dready_hold = 100;
      issue(lw(5'd3, 5'd1)); issue(NOP);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
      g_dready_hold = 0;
      idle(3);

      // randomized traffic on a small register window to provoke hazards
      g_rand_dready = 1'b1;
      rr0 = 0; rr1 = 0; rrd = 0; rvv = 1'b0; rw = 1'b0; rl = 1'b0; ru = 2'b00;
      for (int i = 0; i < 800; i++) begin
         randomize_data();
         if (!m_stall) begin
            rvv = ($urandom_range(0, 3) != 0);
            rr0 = $urandom_range(0, 3);
            rr1 = $urandom_range(0, 3);
            rrd = $urandom_range(0, 3);
            rl  = ($urandom_range(0, 2) == 0);
            rw  = rl || ($urandom_range(0, 3) != 0);
            ru  = 2'($urandom_range(0, 3));
         end
         rfl = ($urandom_range(0, 7) == 0);
         cycle($urandom_range(0, 199) == 0, rvv, rr0, rr1, ru, rrd, rw, rl, rfl);
      end
      g_rand_dready = 1'b0;
      idle(2);

      repeat (4) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
